// File: rtl/divisor_algoritmico_seq.sv
// ============================================================================
//  Module      : divisor_algoritmico_seq
//  Description : Sequential signed divider, restoring shift/subtract,
//                one quotient bit per clock. Quotient truncates toward zero,
//                remainder carries the sign of the numerator.
//  Ports       : CLK     - clock, rising edge
//                RSTa    - synchronous active-high reset
//                Start   - level request, sampled only in IDLE
//                Num/Den - signed dividend / divisor (N bits)
//                Coc/Res - registered signed quotient / remainder
//                Done    - registered one-cycle completion pulse
//                DivZero - (only with DIVISOR_DIV0_FLAG_EN) registered flag,
//                          set on a result load whose divisor was zero
//  Options     : DIVISOR_DIV0_FLAG_EN adds the DivZero output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divisor_algoritmico_seq #(
    parameter int N = 16
) (
    input  logic         CLK,
    input  logic         RSTa,
    input  logic         Start,
    input  logic [N-1:0] Num,
    input  logic [N-1:0] Den,
    output logic [N-1:0] Coc,
    output logic [N-1:0] Res,
    output logic         Done
`ifdef DIVISOR_DIV0_FLAG_EN
    ,
    output logic         DivZero
`endif
);

    localparam int           CW     = $clog2(N + 1);
    localparam logic [CW-1:0] C_LAST = CW'(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [N:0]      rem_q;      // partial remainder
    logic [N-1:0]    dvd_q;      // dividend magnitude, shifts out as quotient shifts in
    logic [N-1:0]    dden_q;     // divisor magnitude
    logic            neg_num_q;  // numerator was negative -> negate remainder
    logic            neg_q;      // signs differ -> negate quotient

    logic [N:0]      rem_d;
    logic [N-1:0]    dvd_d;
    logic [N-1:0]    w_abs_num;
    logic [N-1:0]    w_abs_den;
    logic [N+1:0]    w_rem_sh;
    logic [N+1:0]    w_trial;
    logic [N-1:0]    w_coc;
    logic [N-1:0]    w_res;
    logic            w_den_zero;

    always_comb begin
        // Unsigned magnitudes: the most negative value maps to 2^(N-1).
        w_abs_num = Num[N-1] ? -Num : Num;
        w_abs_den = Den[N-1] ? -Den : Den;

        // One restoring step. One extra top bit keeps the trial sign visible.
        w_rem_sh = {rem_q, dvd_q[N-1]};
        w_trial  = w_rem_sh - {2'b00, dden_q};
        if (!w_trial[N+1]) begin
            rem_d = w_trial[N:0];
            dvd_d = {dvd_q[N-2:0], 1'b1};
        end else begin
            rem_d = w_rem_sh[N:0];
            dvd_d = {dvd_q[N-2:0], 1'b0};
        end

        // A zero divisor yields an all-ones quotient and the untouched
        // numerator as remainder; the quotient is forced so the sign fix-up
        // cannot turn it into +1.
        w_den_zero = (dden_q == '0);
        if (w_den_zero) begin
            w_coc = '1;
        end else begin
            w_coc = neg_q ? -dvd_q : dvd_q;
        end
        w_res = neg_num_q ? -rem_q[N-1:0] : rem_q[N-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RSTa) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dden_q    <= '0;
            neg_num_q <= 1'b0;
            neg_q     <= 1'b0;
            Coc       <= '0;
            Res       <= '0;
            Done      <= 1'b0;
`ifdef DIVISOR_DIV0_FLAG_EN
            DivZero   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        dvd_q     <= w_abs_num;
                        dden_q    <= w_abs_den;
                        neg_num_q <= Num[N-1];
                        neg_q     <= Num[N-1] ^ Den[N-1];
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        state_q   <= S_ITER;
`ifdef DIVISOR_DIV0_FLAG_EN
                        DivZero   <= 1'b0;
`endif
                    end
                end
                S_ITER: begin
                    // N shift/subtract cycles, then one extra cycle that loads
                    // the sign-corrected results together with Done.
                    if (cnt_q == C_LAST) begin
                        Coc     <= w_coc;
                        Res     <= w_res;
                        Done    <= 1'b1;
                        state_q <= S_DONE;
`ifdef DIVISOR_DIV0_FLAG_EN
                        DivZero <= w_den_zero;
`endif
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    Done    <= 1'b0;
                    // A still-high Start must be released before a new run.
                    state_q <= Start ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    Done <= 1'b0;
                    if (!Start) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_divisor_algoritmico_seq.sv
// ============================================================================
//  Module      : tb_divisor_algoritmico_seq
//  Description : Self-checking bench for divisor_algoritmico_seq. Directed
//                cases plus random operands against an integer-arithmetic
//                reference; checks latency, results, Done pulse, handshake
//                and reset abort.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_divisor_algoritmico_seq;

    localparam int N = 16;

    logic         CLK;
    logic         RSTa;
    logic         Start;
    logic [N-1:0] Num;
    logic [N-1:0] Den;
    logic [N-1:0] Coc;
    logic [N-1:0] Res;
    logic         Done;
`ifdef DIVISOR_DIV0_FLAG_EN
    logic         DivZero;
`endif

    int total = 0;
    int bad   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    divisor_algoritmico_seq #(.N(N)) dut (
        .CLK   (CLK),
        .RSTa  (RSTa),
        .Start (Start),
        .Num   (Num),
        .Den   (Den),
        .Coc   (Coc),
        .Res   (Res),
        .Done  (Done)
`ifdef DIVISOR_DIV0_FLAG_EN
        ,
        .DivZero (DivZero)
`endif
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: C-style truncating division on plain integers.
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            q = '1;
            r = a;
        end else begin
            q = N'(sa / sb);
            r = N'(sa % sb);
        end
    endfunction

    task automatic run_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input bit hold, input bit scramble);
        logic [N-1:0] eq;
        logic [N-1:0] er;
        int  edges;
        bit  seen;
        model(a, b, eq, er);
        Num   = a;
        Den   = b;
        Start = 1'b1;
        tick();                     // accepting edge
        if (!hold) Start = 1'b0;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            if (scramble) begin
                Num = N'($urandom);
                Den = N'($urandom);
            end
            tick();
            edges++;
            seen = Done;
        end
        check({tag, " latency"}, 32'(edges), 32'(17));
        check({tag, " coc"}, 32'(Coc), 32'(eq));
        check({tag, " res"}, 32'(Res), 32'(er));
`ifdef DIVISOR_DIV0_FLAG_EN
        check({tag, " divzero"}, 32'(DivZero), 32'(b == '0));
`endif
        tick();
        check({tag, " done pulse"}, 32'(Done), 32'(0));
    endtask

    initial begin
        int pulses;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        RSTa  = 1'b1;
        Start = 1'b0;
        Num   = '0;
        Den   = '0;
        repeat (2) tick();
        check("reset coc", 32'(Coc), 32'(0));
        check("reset res", 32'(Res), 32'(0));
        check("reset done", 32'(Done), 32'(0));
`ifdef DIVISOR_DIV0_FLAG_EN
        check("reset divzero", 32'(DivZero), 32'(0));
`endif
        RSTa = 1'b0;
        tick();

        // Same signs
        run_div("17/3",   N'(17),  N'(3),  1'b0, 1'b0);
        run_div("15/3",   N'(15),  N'(3),  1'b0, 1'b0);
        run_div("-23/-5", N'(-23), N'(-5), 1'b0, 1'b0);
        run_div("-20/-5", N'(-20), N'(-5), 1'b0, 1'b0);
        // Mixed signs
        run_div("17/-3",  N'(17),  N'(-3), 1'b0, 1'b0);
        run_div("18/-3",  N'(18),  N'(-3), 1'b0, 1'b0);
        run_div("-17/3",  N'(-17), N'(3),  1'b0, 1'b0);
        run_div("-18/3",  N'(-18), N'(3),  1'b0, 1'b0);
        // Boundaries
        run_div("min/-1", 16'h8000, N'(-1), 1'b0, 1'b0);
        run_div("5/0",    N'(5),   N'(0),  1'b0, 1'b0);
        run_div("-9/0",   N'(-9),  N'(0),  1'b0, 1'b0);
        run_div("0/7",    N'(0),   N'(7),  1'b0, 1'b0);
        run_div("min/min", 16'h8000, 16'h8000, 1'b0, 1'b0);
        run_div("5/min",  N'(5),   16'h8000, 1'b0, 1'b0);

        // Start held high through Done: one run only
        run_div("hold", N'(1000), N'(7), 1'b1, 1'b0);
        pulses = 0;
        repeat (25) begin
            tick();
            if (Done) pulses++;
        end
        check("hold no retrigger", 32'(pulses), 32'(0));
        Start = 1'b0;
        tick();
        run_div("restart", N'(-1000), N'(7), 1'b0, 1'b0);

        // Inputs changing while busy must not affect the result
        run_div("stable", N'(12345), N'(-67), 1'b0, 1'b1);

        // Reset in the middle of an iteration aborts without a Done pulse
        Num   = N'(100);
        Den   = N'(7);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (5) tick();
        RSTa = 1'b1;
        tick();
        RSTa = 1'b0;
        check("abort coc", 32'(Coc), 32'(0));
        check("abort res", 32'(Res), 32'(0));
        pulses = 0;
        repeat (25) begin
            tick();
            if (Done) pulses++;
        end
        check("abort no done", 32'(pulses), 32'(0));

        // Random operands
        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom);
            case (i % 4)
                0:       rb = N'($urandom);
                1:       rb = N'($urandom_range(1, 40));
                2:       rb = -N'($urandom_range(1, 40));
                default: rb = (i % 8 == 3) ? N'(0) : N'($urandom_range(0, 300));
            endcase
            run_div($sformatf("rand%0d", i), ra, rb, 1'b0, (i % 5 == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/divisor_algoritmico_seq.md
Name: divisor_algoritmico_seq

Overview:
- Sequential signed integer divider using the restoring shift/subtract algorithm, one quotient bit per clock.
- Produces quotient and remainder of two's-complement Num/Den.
- Quotient truncates toward zero; remainder takes the sign of the numerator (C/Verilog semantics).
- Used as a multi-cycle arithmetic slave with a Start/Done handshake.

Parameters:
- N, 16, operand/result width in bits; iteration count equals N.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RSTa  input  1  reset, synchronous, active-high.
- Start  input  1  level request to begin a division; sampled in IDLE.
- Num  input  N  signed dividend (two's complement).
- Den  input  N  signed divisor (two's complement).
- Coc  output  N  signed quotient, registered.
- Res  output  N  signed remainder, registered.
- Done  output  1  registered one-cycle completion pulse.

Behaviour:
- Reset: RSTa=1 at a rising edge forces state IDLE. It also sets Coc=0, Res=0, Done=0 and clears the iteration counter. Reset mid-operation aborts the division; Coc/Res are not updated with partial results.
- States: IDLE, ITER, DONE, WAIT.
- IDLE: Done=0. If Start=1 at edge k, the block captures the following and moves to ITER:
  - unsigned magnitudes |Num| and |Den| (N-bit unsigned, so -2^(N-1) maps to 2^(N-1));
  - sign of Num;
  - Num sign XOR Den sign.
  - The partial remainder (N+1 bits) is cleared and the counter is set to 0.
- ITER: each cycle performs one restoring step:
  - shift {partial remainder, dividend} left by 1;
  - trial-subtract |Den|;
  - if the result is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
  - The counter increments; after N steps (edges k+1..k+N) the state goes to DONE.
- Result load, edge k+N+1 (entering DONE):
  - Coc = quotient, negated if the signs differ.
  - Res = remainder, negated if Num was negative.
  - Done set to 1 on the same edge. Outputs are valid when Done is seen high.
- Done is high for exactly one cycle. At the next edge the state goes to WAIT if Start=1, else IDLE.
- WAIT: holds until Start=0, then goes to IDLE. A Start held high never retriggers a second division.
- Coc/Res hold their last values until the next result load or reset.
- Num/Den changes after the accepting edge have no effect. Start while busy is ignored.
- Latency: N+1 rising edges from the Start-accepting edge to Done=1 (17 for N=16). Back-to-back throughput is at most one division per N+3 cycles.
- Division by zero: no trap. Result is Coc = all ones (-1 pattern), Res = Num, with the normal latency.
- Overflow case Num=-2^(N-1), Den=-1: Coc=-2^(N-1) (wraps), Res=0.
- Num=0 gives Coc=0, Res=0 for any nonzero Den.

Optional Feature:
- Macro DIVISOR_DIV0_FLAG_EN.
- When defined, the block adds output port DivZero (1 bit, registered, reset 0). DivZero is set on the result-load edge when the captured Den was 0, and cleared on the next accepted Start. Coc/Res values follow the division-by-zero rule above.
- When undefined, the port does not exist and behaviour is otherwise identical.

Test Plan:
- Reset: RSTa=1 for 2 cycles -> Coc=0, Res=0, Done=0. Assert RSTa mid-ITER -> return to IDLE, no Done pulse.
- Same signs: 17/3 -> Coc=5, Res=2; 15/3 -> 5, 0; -23/-5 -> 4, -3; -20/-5 -> 4, 0. Done exactly 17 edges after acceptance.
- Mixed signs: 17/-3 -> -5, 2; 18/-3 -> -6, 0; -17/3 -> -5, -2; -18/3 -> -6, 0.
- Handshake: hold Start high through Done -> single Done pulse, no second run. Drop Start, wait one cycle, raise it -> new run starts.
- Boundaries: -32768/-1 -> Coc=-32768, Res=0; 5/0 -> Coc=16'hFFFF, Res=5 (DivZero=1 with DIVISOR_DIV0_FLAG_EN); 0/7 -> 0, 0.
- Input stability: change Num/Den during ITER -> result reflects the values captured at acceptance.
